uart_rx_os16: RTL and testbench

//   UART receiver for the DDS control link: recovers 8-bit bytes from the serial rx line.

---
 rtl/uart_rx_os16.sv | 207 ++++++++++++++++++++
 tb/tb_uart_rx_os16.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x oversampling UART receiver with a valid/ready holding register.
// Bit timing restarts on every start edge. Each bit is decided by a 2-of-3 vote
// taken mid-bit. An optional parity bit follows D7.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | line idle, waiting for a falling edge on the synchronized rx
// START    | qualifying the start bit; a high vote is treated as a glitch
// DATA     | shifting in D0..D7, LSB first
// PARITY   | checking the parity bit against the received byte
// STOP     | stop bit decided at mid-bit, then deliver or flag an error
// BREAK    | line held low after a framing error; wait for it to go high
module uart_rx_os16 #(
  parameter int OS_DIV       = 27,
  parameter int OS_DIV_WIDTH = 16,
  parameter int PARITY       = 0
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  localparam logic [OS_DIV_WIDTH-1:0] DIV_LAST = OS_DIV_WIDTH'(OS_DIV - 1);
  localparam logic                    USE_PAR  = (PARITY != 0);
  localparam logic                    ODD_PAR  = (PARITY == 1);

  logic                    r_rx_meta;
  logic                    r_rx_sync;
  logic                    r_rx_prev;
  logic [2:0]              r_state;
  logic [OS_DIV_WIDTH-1:0] r_div_cnt;
  logic [3:0]              r_os_cnt;
  logic                    r_s7;
  logic                    r_s8;
  logic [2:0]              r_bit_idx;
  logic [7:0]              r_shreg;
  logic                    r_par_fail;
  logic                    r_deliver;
  logic [7:0]              r_rx_data;
  logic                    r_rx_valid;
  logic                    r_frame_err;
  logic                    r_parity_err;
  logic                    r_overrun;

  logic w_fall;
  logic w_tick;
  logic w_at9;
  logic w_at15;
  logic w_vote;
  logic w_par_exp;
  logic w_counting;

  assign w_fall     = r_rx_prev & ~r_rx_sync;
  assign w_tick     = (r_div_cnt == DIV_LAST);
  assign w_at9      = w_tick && (r_os_cnt == 4'd9);
  assign w_at15     = w_tick && (r_os_cnt == 4'd15);
  assign w_vote     = (r_s7 & r_s8) | (r_s7 & r_rx_sync) | (r_s8 & r_rx_sync);
  assign w_par_exp  = ODD_PAR ? ~(^r_shreg) : (^r_shreg);
  assign w_counting = (r_state != ST_IDLE) && (r_state != ST_BREAK);

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;

  // Two-flop synchronizer plus a history flop for falling-edge detection; idles high.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // Oversample tick divider and 16-step bit phase; held at zero while not in a frame
  // so timing restarts from the start edge.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
      r_os_cnt  <= 4'd0;
    end else if (!w_counting) begin
      r_div_cnt <= '0;
      r_os_cnt  <= 4'd0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_os_cnt  <= r_os_cnt + 4'd1;
    end else begin
      r_div_cnt <= r_div_cnt + OS_DIV_WIDTH'(1);
    end
  end

  // First two vote samples; the third one is the live synchronized value at phase 9.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_s7 <= 1'b0;
      r_s8 <= 1'b0;
    end else if (w_tick) begin
      if (r_os_cnt == 4'd7) r_s7 <= r_rx_sync;
      if (r_os_cnt == 4'd8) r_s8 <= r_rx_sync;
    end
  end

  // Frame sequencer: start qualification, data shift, parity check, stop decision.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_bit_idx    <= 3'd0;
      r_shreg      <= 8'h00;
      r_par_fail   <= 1'b0;
      r_deliver    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_deliver    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state    <= ST_START;
            r_par_fail <= 1'b0;
          end
        end
        ST_START: begin
          if (w_at9 && w_vote) begin
            r_state <= ST_IDLE;
          end else if (w_at15) begin
            r_state   <= ST_DATA;
            r_bit_idx <= 3'd0;
          end
        end
        ST_DATA: begin
          if (w_at9) r_shreg <= {w_vote, r_shreg[7:1]};
          if (w_at15) begin
            if (r_bit_idx == 3'd7) begin
              r_state <= USE_PAR ? ST_PARITY : ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (w_at9 && (w_vote != w_par_exp)) r_par_fail <= 1'b1;
          if (w_at15) r_state <= ST_STOP;
        end
        ST_STOP: begin
          if (w_at9) begin
            if (!w_vote) begin
              r_frame_err <= 1'b1;
              r_state     <= ST_BREAK;
            end else if (r_par_fail) begin
              r_parity_err <= 1'b1;
              r_state      <= ST_IDLE;
            end else begin
              r_deliver <= 1'b1;
              r_state   <= ST_IDLE;
            end
          end
        end
        ST_BREAK: begin
          if (r_rx_sync) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Holding register: load on delivery unless full and not being drained, which is an overrun.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_deliver) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_data  <= r_shreg;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: one receiver without parity, one with even parity,
// both at OS_DIV=4 so a nominal bit is 64 clocks.
module tb_uart_rx_os16;

  logic       clk;
  logic       rst;
  logic       rx0, rx2;
  logic       rx_ready0, rx_ready2;
  logic [7:0] rx_data0, rx_data2;
  logic       rx_valid0, rx_valid2;
  logic       ferr0, ferr2, perr0, perr2, ovr0, ovr2;

  int errors;
  int checks;

  int acc0, acc2, fe0, fe2, pe0, pe2, ov0, ov2;
  logic [7:0] last0, last2;

  uart_rx_os16 #(.OS_DIV(4), .OS_DIV_WIDTH(16), .PARITY(0)) dut0 (
    .clock(clk), .rst(rst), .rx(rx0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
    .frame_err(ferr0), .parity_err(perr0), .overrun(ovr0)
  );

  uart_rx_os16 #(.OS_DIV(4), .OS_DIV_WIDTH(16), .PARITY(2)) dut2 (
    .clock(clk), .rst(rst), .rx(rx2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(rx_ready2),
    .frame_err(ferr2), .parity_err(perr2), .overrun(ovr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted bytes and high cycles of each error pulse, per receiver.
  always @(posedge clk) begin
    if (rx_valid0 && rx_ready0) begin
      acc0  <= acc0 + 1;
      last0 <= rx_data0;
    end
    if (rx_valid2 && rx_ready2) begin
      acc2  <= acc2 + 1;
      last2 <= rx_data2;
    end
    if (ferr0) fe0 <= fe0 + 1;
    if (ferr2) fe2 <= fe2 + 1;
    if (perr0) pe0 <= pe0 + 1;
    if (perr2) pe2 <= pe2 + 1;
    if (ovr0)  ov0 <= ov0 + 1;
    if (ovr2)  ov2 <= ov2 + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic v);
    if (sel == 0) rx0 = v;
    else          rx2 = v;
  endtask

  // par < 0: no parity bit; otherwise par[0] is sent. Line is left at the stop level.
  task automatic send(input int sel, input logic [7:0] d, input int par,
                      input logic stopv, input int p);
    drive(sel, 1'b0);
    clocks(p);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      clocks(p);
    end
    if (par >= 0) begin
      drive(sel, par[0]);
      clocks(p);
    end
    drive(sel, stopv);
    clocks(p);
  endtask

  int a0, f0, p0, o0, a2, p2, f2;

  initial begin
    errors = 0; checks = 0;
    acc0 = 0; acc2 = 0; fe0 = 0; fe2 = 0; pe0 = 0; pe2 = 0; ov0 = 0; ov2 = 0;
    last0 = 8'h00; last2 = 8'h00;
    rst = 1'b0; rx0 = 1'b1; rx2 = 1'b1; rx_ready0 = 1'b1; rx_ready2 = 1'b1;
    clocks(5);
    @(negedge clk);
    check("reset rx_valid", rx_valid0, 0);
    check("reset rx_data", rx_data0, 8'h00);
    check("reset errs", {ferr0, perr0, ovr0, ferr2, perr2, ovr2}, 0);
    rst = 1'b1;
    clocks(10);

    // 1: plain 8N1 frame
    send(0, 8'h55, -1, 1'b1, 64);
    clocks(80);
    @(negedge clk);
    check("t1 deliveries", acc0, 1);
    check("t1 data", last0, 8'h55);
    check("t1 no errors", fe0 + pe0 + ov0, 0);
    check("t1 valid drained", rx_valid0, 0);

    // 2: short low glitch is rejected, then a real frame
    a0 = acc0;
    drive(0, 1'b0); clocks(20); drive(0, 1'b1);
    clocks(100);
    @(negedge clk);
    check("t2 glitch no delivery", acc0, a0);
    check("t2 glitch no pulses", fe0 + pe0 + ov0, 0);
    send(0, 8'hA3, -1, 1'b1, 64);
    clocks(80);
    @(negedge clk);
    check("t2 deliveries", acc0, a0 + 1);
    check("t2 data", last0, 8'hA3);

    // 3: stop bit low then line held low: one frame error, then recovery
    a0 = acc0; f0 = fe0;
    send(0, 8'h0F, -1, 1'b0, 64);
    clocks(500);
    @(negedge clk);
    check("t3 one frame_err", fe0, f0 + 1);
    check("t3 no delivery", acc0, a0);
    drive(0, 1'b1);
    clocks(64);
    send(0, 8'h81, -1, 1'b1, 64);
    clocks(80);
    @(negedge clk);
    check("t3 frame_err total", fe0, f0 + 1);
    check("t3 recovery data", last0, 8'h81);
    check("t3 recovery count", acc0, a0 + 1);

    // 4: even parity receiver
    a2 = acc2; p2 = pe2; f2 = fe2;
    send(2, 8'h03, 0, 1'b1, 64);
    clocks(80);
    @(negedge clk);
    check("t4 good parity count", acc2, a2 + 1);
    check("t4 good parity data", last2, 8'h03);
    send(2, 8'h07, 0, 1'b1, 64);
    clocks(80);
    @(negedge clk);
    check("t4 parity_err", pe2, p2 + 1);
    check("t4 bad parity no delivery", acc2, a2 + 1);
    check("t4 no frame_err", fe2, f2);
    check("t4 valid low", rx_valid2, 0);
    check("t4 no parity_err on PARITY=0", pe0, 0);

    // 5: consumer stalled: second byte overruns
    a0 = acc0; o0 = ov0;
    rx_ready0 = 1'b0;
    send(0, 8'h11, -1, 1'b1, 64);
    clocks(80);
    @(negedge clk);
    check("t5 first held valid", rx_valid0, 1);
    check("t5 first held data", rx_data0, 8'h11);
    send(0, 8'h22, -1, 1'b1, 64);
    clocks(80);
    @(negedge clk);
    check("t5 overrun", ov0, o0 + 1);
    check("t5 data kept", rx_data0, 8'h11);
    check("t5 still valid", rx_valid0, 1);
    @(posedge clk); #1;
    rx_ready0 = 1'b1;
    @(posedge clk); #1;
    rx_ready0 = 1'b0;
    @(negedge clk);
    check("t5 drained", rx_valid0, 0);
    check("t5 accepted byte", last0, 8'h11);
    check("t5 accept count", acc0, a0 + 1);

    // 6: async reset mid-frame while a byte is held
    send(0, 8'h3C, -1, 1'b1, 64);
    clocks(80);
    @(negedge clk);
    check("t6 held before reset", rx_data0, 8'h3C);
    @(posedge clk); #1;
    drive(0, 1'b0); clocks(64);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1); clocks(64);
    end
    clocks(32);
    rst = 1'b0;
    #1;
    check("t6 reset valid", rx_valid0, 0);
    check("t6 reset data", rx_data0, 8'h00);
    check("t6 reset pulses", {ferr0, perr0, ovr0}, 0);
    drive(0, 1'b1);
    rx_ready0 = 1'b1;
    clocks(5);
    rst = 1'b1;
    clocks(64);
    a0 = acc0; f0 = fe0;
    send(0, 8'h5A, -1, 1'b1, 64);
    clocks(80);
    @(negedge clk);
    check("t6 after reset data", last0, 8'h5A);
    check("t6 after reset count", acc0, a0 + 1);

    // baud mismatch, slow and fast
    send(0, 8'hC6, -1, 1'b1, 61);
    clocks(80);
    @(negedge clk);
    check("baud 61 data", last0, 8'hC6);
    check("baud 61 count", acc0, a0 + 2);
    send(0, 8'hC6, -1, 1'b1, 67);
    clocks(80);
    @(negedge clk);
    check("baud 67 data", last0, 8'hC6);
    check("baud 67 count", acc0, a0 + 3);
    check("baud no frame_err", fe0, f0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
